// File: rtl/seq_shift_unit.sv
// Multi-cycle shifter: left, logical-right or arithmetic-right by 0..2^SHAMT_W-1
// positions, one bit per clock, behind a start/busy/done handshake.
module seq_shift_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               shift_lr,
  input  logic               arith,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   data_out,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [SHAMT_W-1:0] count, count_nxt;
  logic [WIDTH-1:0]   data_nxt;
  logic               right_q, right_nxt;
  logic               arith_q, arith_nxt;
  logic               busy_nxt, done_nxt;

  function automatic logic [WIDTH-1:0] shift_step(input logic [WIDTH-1:0] r,
                                                  input logic right,
                                                  input logic sign_fill);
    if (!right)
      return {r[WIDTH-2:0], 1'b0};
    else if (sign_fill)
      return {r[WIDTH-1], r[WIDTH-1:1]};
    else
      return {1'b0, r[WIDTH-1:1]};
  endfunction

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // data_out doubles as the working shift register, so intermediate values
  // are visible during SHIFT and the final value is held through IDLE.
  always_comb begin
    state_nxt = state;
    data_nxt  = data_out;
    count_nxt = count;
    right_nxt = right_q;
    arith_nxt = arith_q;
    case (state)
      IDLE: begin
        if (start) begin
          data_nxt  = data_in;
          count_nxt = shamt;
          right_nxt = shift_lr;
          arith_nxt = arith;
          state_nxt = (shamt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        data_nxt  = shift_step(data_out, right_q, arith_q);
        count_nxt = count - SHAMT_W'(1);
        if (count == SHAMT_W'(1))
          state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == DONE);
  end

  // Flags are derived from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
      count    <= '0;
      right_q  <= 1'b0;
      arith_q  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      data_out <= data_nxt;
      count    <= count_nxt;
      right_q  <= right_nxt;
      arith_q  <= arith_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
    end
  end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Self-checking bench for seq_shift_unit: directed cases plus random operations
// compared against a plain-arithmetic reference model.
module tb_seq_shift_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic        shift_lr;
  logic        arith;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic [31:0] data_out;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  seq_shift_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .shift_lr (shift_lr),
    .arith    (arith),
    .data_in  (data_in),
    .shamt    (shamt),
    .data_out (data_out),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  function automatic logic [31:0] model(input logic [31:0] din, input logic [4:0] sa,
                                        input logic lr, input logic ar);
    if (!lr)
      return din << sa;
    else if (ar)
      return $unsigned($signed(din) >>> sa);
    else
      return din >> sa;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // inject_at >= 1 pulses a junk start on that busy cycle, which must be ignored.
  task automatic applyStimulus(input logic [31:0] din, input logic [4:0] sa,
                               input logic lr, input logic ar, input int inject_at);
    logic [31:0] exp;
    int          cycles;
    exp      = model(din, sa, lr, ar);
    data_in  = din;
    shamt    = sa;
    shift_lr = lr;
    arith    = ar;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    data_in  = $urandom;
    shamt    = 5'($urandom);
    shift_lr = 1'($urandom);
    arith    = 1'($urandom);
    checkOutput("busy_after_accept", 32'(busy), 32'd1);
    cycles = 1;
    while (done !== 1'b1 && cycles < int'(sa) + 4) begin
      if (cycles == inject_at) begin
        start   = 1'b1;
        data_in = 32'hFFFF_FFFF;
      end else begin
        start = 1'b0;
      end
      tick();
      cycles++;
    end
    start = 1'b0;
    checkOutput("latency", 32'(cycles), 32'(sa) + 32'd1);
    checkOutput("result", data_out, exp);
    tick();
    checkOutput("done_single_pulse", 32'(done), 32'd0);
    checkOutput("idle_not_busy", 32'(busy), 32'd0);
    checkOutput("hold_result", data_out, exp);
  endtask

  initial begin
    int          pulses;
    logic [31:0] rd;
    logic [4:0]  rs;
    logic        rl, ra;

    rst      = 1'b1;
    start    = 1'b1;
    shift_lr = 1'b0;
    arith    = 1'b0;
    data_in  = 32'h1234_5678;
    shamt    = 5'd3;
    $display("[TB] reset with start held");
    tick();
    tick();
    checkOutput("reset_data_out", data_out, 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    rst   = 1'b0;
    start = 1'b0;
    tick();
    checkOutput("no_accept_in_reset", 32'(busy), 32'd0);

    $display("[TB] directed shifts");
    applyStimulus(32'h0000_0001, 5'd31, 1'b0, 1'b0, -1);
    applyStimulus(32'h8000_00F0, 5'd4, 1'b1, 1'b0, -1);
    applyStimulus(32'h8000_00F0, 5'd4, 1'b1, 1'b1, -1);
    applyStimulus(32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, -1);
    applyStimulus(32'h8000_0000, 5'd31, 1'b1, 1'b1, -1);
    applyStimulus(32'h8000_0000, 5'd31, 1'b1, 1'b0, -1);

    $display("[TB] start ignored while busy");
    applyStimulus(32'h0000_00A5, 5'd8, 1'b0, 1'b0, 3);

    $display("[TB] reset mid-operation");
    data_in  = 32'hCAFE_F00D;
    shamt    = 5'd10;
    shift_lr = 1'b0;
    arith    = 1'b0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_done", 32'(done), 32'd0);
    checkOutput("midreset_data_out", data_out, 32'd0);
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    checkOutput("no_done_after_reset", 32'(pulses), 32'd0);
    applyStimulus(32'h0F0F_0F0F, 5'd5, 1'b1, 1'b0, -1);

    // With start held, done should appear at relative cycles 4 and 9 (shamt+2 apart).
    $display("[TB] back-to-back with start held");
    data_in  = 32'h0000_0003;
    shamt    = 5'd3;
    shift_lr = 1'b0;
    arith    = 1'b0;
    start    = 1'b1;
    tick();
    for (int c = 1; c <= 11; c++) begin
      checkOutput($sformatf("b2b_done_c%0d", c), 32'(done),
                  ((c == 4) || (c == 9)) ? 32'd1 : 32'd0);
      if (c == 9) checkOutput("b2b_result", data_out, 32'h0000_0018);
      if (c == 9) start = 1'b0;
      tick();
    end
    start = 1'b0;
    tick();

    $display("[TB] random operations");
    for (int k = 0; k < 24; k++) begin
      rd = $urandom;
      rs = 5'($urandom_range(0, 31));
      rl = 1'($urandom);
      ra = 1'($urandom);
      applyStimulus(rd, rs, rl, ra, (k % 3 == 0 && rs > 2) ? 2 : -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
